tap_fastload: RTL and testbench
===============================

Name: tap_fastload

Overview:
- Fast-loader for Oric .TAP images held in the tape cache BRAM.
- Parses the first program's sync, header and filename, then DMA-writes the payload through the second port of the main 64K dpram.
- Reports `loadpoint` and the autorun flag to oricatmos `tape_addr` / `tape_complete`.
- Sits between the tape cache read port and the RAM write port, in parallel with the bit-level `cassette` player.

Parameters:
- RD_LAT, 1, cache read latency in cycles from `cache_rd` to valid `cache_data`.
- MIN_SYNC, 3, minimum consecutive 0x16 bytes required before 0x24.
- MAX_NAME, 16, maximum filename length excluding the 0x00 terminator.

Ports:
- clk  in  1  system clock (clk_48 domain)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin parse at cache address 0
- abort  in  1  level: return to IDLE immediately (cache being rewritten)
- tape_end  in  25  address of last valid byte in cache
- cache_addr  out  25  cache read address
- cache_rd  out  1  one-cycle read strobe
- cache_data  in  8  cache read data, valid RD_LAT cycles after `cache_rd`
- tape_addr  out  16  RAM write address
- tape_dout  out  8  RAM write data
- tape_wr  out  1  one-cycle RAM write strobe
- loadpoint  out  16  program start address from header
- tape_autorun  out  1  header autorun byte nonzero
- tape_complete  out  1  level: load finished successfully
- busy  out  1  parse or DMA in progress
- error  out  1  level: malformed or truncated tape

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; byte pointer is 0.
  - All outputs are 0: `cache_addr`, `cache_rd`, `tape_addr`, `tape_dout`, `tape_wr`, `loadpoint`, `tape_autorun`, `tape_complete`, `busy`, `error`.
- Byte fetch:
  - Every byte is fetched by driving `cache_addr` = ptr with `cache_rd` high for 1 cycle.
  - The FSM waits RD_LAT cycles, samples `cache_data`, then increments ptr.
  - No new read is issued while one is outstanding.
  - One byte takes RD_LAT+1 cycles.
- Truncation: if ptr > `tape_end` when a fetch is due, go to ERR.
- States:
  - IDLE: `busy`=0. On `start`: clear `tape_complete`, `error`, `tape_autorun` and `loadpoint`; set ptr=0; go to SYNC.
  - SYNC:
    - 0x16 → sync count +1, saturating at 255.
    - 0x24 with count ≥ MIN_SYNC → HDR; 0x24 with count < MIN_SYNC → count=0, stay.
    - Any other byte → count=0.
  - HDR: reads 9 bytes: [0..1] ignored, [2] type (ignored), [3] autorun, [4] end_hi, [5] end_lo, [6] start_hi, [7] start_lo, [8] ignored.
    - After byte 8: if end < start → ERR, else → NAME.
  - NAME:
    - Consume bytes until 0x00 → DATA.
    - A 17th nonzero byte (MAX_NAME+1) → ERR.
  - DATA:
    - For n = 0 .. end−start, the fetched byte drives `tape_dout`, with `tape_addr` = start+n and `tape_wr` high for exactly 1 cycle (the cycle after sampling).
    - The byte counter is 17 bits, so start=0x0000, end=0xFFFF writes 65536 bytes.
    - `tape_addr` never wraps.
    - After the last write → DONE.
  - DONE:
    - `loadpoint` = start address; `tape_autorun` = (autorun byte != 0); `tape_complete`=1.
    - All three hold until the next `start` or reset.
    - Return to IDLE with `busy`=0.
  - ERR: `error`=1, `tape_complete`=0, `busy`=0. Bytes already written stay in RAM. Held until the next `start`.
- `busy`=1 in SYNC, HDR, NAME and DATA.
- `start` while `busy` is ignored.
- `abort` overrides `start` in the same cycle. Any state → IDLE next cycle, with:
  - `tape_wr` and `cache_rd` forced 0 that cycle;
  - `tape_complete` and `error` cleared;
  - no further writes.
- A read in flight when `abort` asserts is discarded.

Optional Feature:
- Macro TAPLOAD_MULTI_EN.
- Defined: DATA completion with ptr ≤ `tape_end` returns to SYNC (count=0) and loads the next program.
  - `loadpoint` and `tape_autorun` take the last program's header.
  - `tape_complete` is asserted only when ptr > `tape_end` while in SYNC with zero sync bytes seen.
  - Running out of cache in any other state or partway through SYNC → ERR.
- Undefined: only the first program is loaded and the remainder of the cache is ignored.

Test Plan:
- Tape = 4×0x16, 0x24, 00 00 80 C7 05 02 05 00 00, "AB",00, 3 bytes 11 22 33; `start` → writes 0x0500=11, 0x0501=22, 0x0502=33, one `tape_wr` per byte; `loadpoint`=0x0500, `tape_autorun`=1, `tape_complete`=1, `error`=0.
- Same tape with autorun byte 00 and RD_LAT=2 → identical writes; `tape_autorun`=0; per-byte spacing of 3 cycles.
- Sync 0x16,0x16,0x24,0x16,0x16,0x16,0x24 then a valid header → first 0x24 rejected (count 2), load succeeds from second.
- Header end=0x04FF, start=0x0500 → `error`=1 after header byte 8, no `tape_wr`.
- `tape_end` set 1 byte short of payload → 2 writes, then `error`=1, `tape_complete`=0.
- `abort` asserted mid-DATA after 1 write → next cycle IDLE, `busy`=0, no further `tape_wr`; later `start` reloads cleanly. With TAPLOAD_MULTI_EN, two concatenated programs → both regions written, `loadpoint` = second start.

Source files
------------

// File: rtl/tap_fastload_if.sv
// Bus bundle for tap_fastload: control/status, tape cache read port and
// main RAM write port. "master" is the loader side, "slave" the environment.
interface tap_fastload_if;
  logic        start;
  logic        abort;
  logic [24:0] tape_end;
  logic [24:0] cache_addr;
  logic        cache_rd;
  logic [7:0]  cache_data;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_wr;
  logic [15:0] loadpoint;
  logic        tape_autorun;
  logic        tape_complete;
  logic        busy;
  logic        error;

  modport master (
    input  start, abort, tape_end, cache_data,
    output cache_addr, cache_rd, tape_addr, tape_dout, tape_wr,
           loadpoint, tape_autorun, tape_complete, busy, error
  );

  modport slave (
    output start, abort, tape_end, cache_data,
    input  cache_addr, cache_rd, tape_addr, tape_dout, tape_wr,
           loadpoint, tape_autorun, tape_complete, busy, error
  );
endinterface

// File: rtl/tap_fastload.sv
// tap_fastload: Oric .TAP fast loader. Parses sync, header and filename from
// the tape cache, then writes the payload into main RAM.
// Optional macro TAPLOAD_MULTI_EN: keep loading concatenated programs until
// the cache is exhausted between programs.
module tap_fastload #(
  parameter int RD_LAT   = 1,
  parameter int MIN_SYNC = 3,
  parameter int MAX_NAME = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  tap_fastload_if.master bus
);

  localparam int LAT_W  = $clog2(RD_LAT + 2);
  localparam int NAME_W = $clog2(MAX_NAME + 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_HDR, ST_NAME, ST_DATA, ST_DONE, ST_ERR
  } state_e;

  state_e state_q, state_d;

  logic [24:0]       ptr_q, ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [7:0]        sync_cnt_q, sync_cnt_d;
  logic [3:0]        hdr_idx_q, hdr_idx_d;
  logic [NAME_W-1:0] name_cnt_q, name_cnt_d;
  logic [16:0]       data_cnt_q, data_cnt_d;
  logic [7:0]        hdr_auto_q, hdr_auto_d;
  logic [15:0]       hdr_end_q, hdr_end_d;
  logic [15:0]       hdr_start_q, hdr_start_d;

  logic [24:0] cache_addr_q, cache_addr_d;
  logic        cache_rd_q, cache_rd_d;
  logic [15:0] tape_addr_q, tape_addr_d;
  logic [7:0]  tape_dout_q, tape_dout_d;
  logic        tape_wr_q, tape_wr_d;
  logic [15:0] loadpoint_q, loadpoint_d;
  logic        tape_autorun_q, tape_autorun_d;
  logic        tape_complete_q, tape_complete_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;

  logic        sample_s;
  logic        fetch_due_s;
  logic [15:0] len_s;

  // States that consume bytes from the cache
  function automatic logic is_fetch(input state_e s);
    is_fetch = (s == ST_SYNC) || (s == ST_HDR) || (s == ST_NAME) || (s == ST_DATA);
  endfunction

  // The outstanding read's data is valid in the cycle its latency count hits RD_LAT
  assign sample_s = rd_pend_q && (lat_q == LAT_W'(RD_LAT));
  assign len_s    = hdr_end_q - hdr_start_q;

  // Next-state, byte parser, fetch sequencing and registered output values
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    rd_pend_d       = rd_pend_q;
    lat_d           = rd_pend_q ? (lat_q + LAT_W'(1)) : lat_q;
    sync_cnt_d      = sync_cnt_q;
    hdr_idx_d       = hdr_idx_q;
    name_cnt_d      = name_cnt_q;
    data_cnt_d      = data_cnt_q;
    hdr_auto_d      = hdr_auto_q;
    hdr_end_d       = hdr_end_q;
    hdr_start_d     = hdr_start_q;
    cache_addr_d    = cache_addr_q;
    cache_rd_d      = 1'b0;
    tape_addr_d     = tape_addr_q;
    tape_dout_d     = tape_dout_q;
    tape_wr_d       = 1'b0;
    loadpoint_d     = loadpoint_q;
    tape_autorun_d  = tape_autorun_q;
    tape_complete_d = tape_complete_q;
    error_d         = error_q;
    fetch_due_s     = 1'b0;

    if (bus.abort) begin
      // Abort drops any in-flight read and leaves the loader idle
      state_d         = ST_IDLE;
      rd_pend_d       = 1'b0;
      lat_d           = '0;
      tape_complete_d = 1'b0;
      error_d         = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            tape_complete_d = 1'b0;
            error_d         = 1'b0;
            tape_autorun_d  = 1'b0;
            loadpoint_d     = 16'h0000;
            ptr_d           = 25'd0;
            sync_cnt_d      = 8'd0;
            rd_pend_d       = 1'b0;
            state_d         = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SYNC: begin
          if (sample_s) begin
            rd_pend_d = 1'b0;
            ptr_d     = ptr_q + 25'd1;
            if (bus.cache_data == 8'h16) begin
              sync_cnt_d = (sync_cnt_q == 8'hFF) ? 8'hFF : (sync_cnt_q + 8'd1);
            end else if ((bus.cache_data == 8'h24) && (sync_cnt_q >= 8'(MIN_SYNC))) begin
              hdr_idx_d = 4'd0;
              state_d   = ST_HDR;
            end else begin
              sync_cnt_d = 8'd0;
            end
          end else begin
            rd_pend_d = rd_pend_q;
          end
        end
        ST_HDR: begin
          if (sample_s) begin
            rd_pend_d = 1'b0;
            ptr_d     = ptr_q + 25'd1;
            hdr_idx_d = hdr_idx_q + 4'd1;
            case (hdr_idx_q)
              4'd3:    hdr_auto_d        = bus.cache_data;
              4'd4:    hdr_end_d[15:8]   = bus.cache_data;
              4'd5:    hdr_end_d[7:0]    = bus.cache_data;
              4'd6:    hdr_start_d[15:8] = bus.cache_data;
              4'd7:    hdr_start_d[7:0]  = bus.cache_data;
              default: hdr_auto_d        = hdr_auto_q;
            endcase
            if (hdr_idx_q == 4'd8) begin
              if (hdr_end_q < hdr_start_q) begin
                state_d = ST_ERR;
              end else begin
                name_cnt_d = '0;
                state_d    = ST_NAME;
              end
            end else begin
              state_d = ST_HDR;
            end
          end else begin
            rd_pend_d = rd_pend_q;
          end
        end
        ST_NAME: begin
          if (sample_s) begin
            rd_pend_d = 1'b0;
            ptr_d     = ptr_q + 25'd1;
            if (bus.cache_data == 8'h00) begin
              data_cnt_d = 17'd0;
              state_d    = ST_DATA;
            end else if (name_cnt_q == NAME_W'(MAX_NAME)) begin
              state_d = ST_ERR;
            end else begin
              name_cnt_d = name_cnt_q + NAME_W'(1);
            end
          end else begin
            rd_pend_d = rd_pend_q;
          end
        end
        ST_DATA: begin
          if (sample_s) begin
            rd_pend_d   = 1'b0;
            ptr_d       = ptr_q + 25'd1;
            tape_wr_d   = 1'b1;
            tape_dout_d = bus.cache_data;
            tape_addr_d = hdr_start_q + data_cnt_q[15:0];
            data_cnt_d  = data_cnt_q + 17'd1;
            if (data_cnt_q == {1'b0, len_s}) begin
`ifdef TAPLOAD_MULTI_EN
              if (ptr_d <= bus.tape_end) begin
                sync_cnt_d = 8'd0;
                state_d    = ST_SYNC;
              end else begin
                state_d = ST_DONE;
              end
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            rd_pend_d = rd_pend_q;
          end
        end
        ST_DONE: begin
          loadpoint_d     = hdr_start_q;
          tape_autorun_d  = (hdr_auto_q != 8'h00);
          tape_complete_d = 1'b1;
          state_d         = ST_IDLE;
        end
        ST_ERR: begin
          error_d         = 1'b1;
          tape_complete_d = 1'b0;
          rd_pend_d       = 1'b0;
          state_d         = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          rd_pend_d = 1'b0;
        end
      endcase

      // Issue the next read in the same cycle the previous byte is consumed
      fetch_due_s = is_fetch(state_q) && is_fetch(state_d) && (!rd_pend_q || sample_s);
      if (fetch_due_s) begin
        if (ptr_d > bus.tape_end) begin
          rd_pend_d = 1'b0;
`ifdef TAPLOAD_MULTI_EN
          // Cache ran out cleanly between programs: that is a finished load
          if ((state_d == ST_SYNC) && (sync_cnt_d == 8'd0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
`else
          state_d = ST_ERR;
`endif
        end else begin
          cache_rd_d   = 1'b1;
          cache_addr_d = ptr_d;
          rd_pend_d    = 1'b1;
          lat_d        = '0;
        end
      end else begin
        cache_rd_d = 1'b0;
      end
    end

    busy_d = is_fetch(state_d);
  end

  // State, parser context and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      ptr_q           <= 25'd0;
      rd_pend_q       <= 1'b0;
      lat_q           <= '0;
      sync_cnt_q      <= 8'd0;
      hdr_idx_q       <= 4'd0;
      name_cnt_q      <= '0;
      data_cnt_q      <= 17'd0;
      hdr_auto_q      <= 8'd0;
      hdr_end_q       <= 16'd0;
      hdr_start_q     <= 16'd0;
      cache_addr_q    <= 25'd0;
      cache_rd_q      <= 1'b0;
      tape_addr_q     <= 16'd0;
      tape_dout_q     <= 8'd0;
      tape_wr_q       <= 1'b0;
      loadpoint_q     <= 16'd0;
      tape_autorun_q  <= 1'b0;
      tape_complete_q <= 1'b0;
      busy_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      rd_pend_q       <= rd_pend_d;
      lat_q           <= lat_d;
      sync_cnt_q      <= sync_cnt_d;
      hdr_idx_q       <= hdr_idx_d;
      name_cnt_q      <= name_cnt_d;
      data_cnt_q      <= data_cnt_d;
      hdr_auto_q      <= hdr_auto_d;
      hdr_end_q       <= hdr_end_d;
      hdr_start_q     <= hdr_start_d;
      cache_addr_q    <= cache_addr_d;
      cache_rd_q      <= cache_rd_d;
      tape_addr_q     <= tape_addr_d;
      tape_dout_q     <= tape_dout_d;
      tape_wr_q       <= tape_wr_d;
      loadpoint_q     <= loadpoint_d;
      tape_autorun_q  <= tape_autorun_d;
      tape_complete_q <= tape_complete_d;
      busy_q          <= busy_d;
      error_q         <= error_d;
    end
  end

  assign bus.cache_addr    = cache_addr_q;
  assign bus.cache_rd      = cache_rd_q;
  assign bus.tape_addr     = tape_addr_q;
  assign bus.tape_dout     = tape_dout_q;
  assign bus.tape_wr       = tape_wr_q;
  assign bus.loadpoint     = loadpoint_q;
  assign bus.tape_autorun  = tape_autorun_q;
  assign bus.tape_complete = tape_complete_q;
  assign bus.busy          = busy_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_tap_fastload.sv
// Directed bench for tap_fastload: one loader with RD_LAT=1, one with RD_LAT=2,
// both fed from a shared tape image and logging their RAM writes.
module tb_tap_fastload;

  logic clk = 1'b0;
  logic reset_n;

  // 10 ns clock
  always #5 clk = ~clk;

  tap_fastload_if bus1();
  tap_fastload_if bus2();

  tap_fastload #(.RD_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  tap_fastload #(.RD_LAT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  logic [7:0]  tape_mem [0:63];
  int          tlen;
  logic [7:0]  c2_stage;

  int          n_checks = 0;
  int          n_fails  = 0;

  int          wcnt1 = 0;
  int          wcnt2 = 0;
  int          cyc   = 0;
  logic [15:0] wa1 [0:63];
  logic [7:0]  wd1 [0:63];
  logic [15:0] wa2 [0:63];
  logic [7:0]  wd2 [0:63];
  int          wcyc2 [0:63];

  // Cache models: one- and two-cycle read latency from the registered address
  always @(posedge clk) begin
    bus1.cache_data <= tape_mem[bus1.cache_addr[5:0]];
    c2_stage        <= tape_mem[bus2.cache_addr[5:0]];
    bus2.cache_data <= c2_stage;
  end

  // RAM write logger, sampled mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus1.tape_wr) begin
      wa1[wcnt1 % 64] <= bus1.tape_addr;
      wd1[wcnt1 % 64] <= bus1.tape_dout;
      wcnt1           <= wcnt1 + 1;
    end
    if (bus2.tape_wr) begin
      wa2[wcnt2 % 64]   <= bus2.tape_addr;
      wd2[wcnt2 % 64]   <= bus2.tape_dout;
      wcyc2[wcnt2 % 64] <= cyc;
      wcnt2             <= wcnt2 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    tape_mem[tlen] = b;
    tlen++;
  endtask

  // Sync run, 0x24, header, filename, terminator and payload (k+1)*0x11
  task automatic make_prog(input logic [7:0] auto_b, input logic [15:0] e, input logic [15:0] s,
                           input int nsync, input int nname, input int ndata);
    for (int i = 0; i < nsync; i++) put(8'h16);
    put(8'h24);
    put(8'h00); put(8'h00); put(8'h80); put(auto_b);
    put(e[15:8]); put(e[7:0]); put(s[15:8]); put(s[7:0]); put(8'h00);
    for (int i = 0; i < nname; i++) put(8'(8'h41 + i));
    put(8'h00);
    for (int i = 0; i < ndata; i++) put(8'((i + 1) * 17));
  endtask

  // Pulse start on the selected loader and wait (bounded) for complete or error
  task automatic load(input int sel, input string tag);
    logic fin;
    fin = 1'b0;
    @(negedge clk);
    if (sel == 1) bus1.start = 1'b1; else bus2.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (sel == 1) fin = bus1.tape_complete | bus1.error;
      else          fin = bus2.tape_complete | bus2.error;
      if (fin) break;
      @(negedge clk);
    end
    check_eq(tag, {31'd0, fin}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    logic seen;
    for (int i = 0; i < 64; i++) tape_mem[i] = 8'h00;
    tlen = 0;
    reset_n = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.tape_end = 25'd0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.tape_end = 25'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy",  {31'd0, bus1.busy}, 32'd0);
    check_eq("rst_err",   {31'd0, bus1.error}, 32'd0);
    check_eq("rst_cmpl",  {31'd0, bus1.tape_complete}, 32'd0);
    check_eq("rst_lp",    {16'd0, bus1.loadpoint}, 32'd0);
    check_eq("rst_rdwr",  {30'd0, bus1.cache_rd, bus1.tape_wr}, 32'd0);
    check_eq("rst_addr",  {7'd0, bus1.cache_addr}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load with trailing junk after the program
    tlen = 0;
    make_prog(8'hC7, 16'h0502, 16'h0500, 4, 2, 3);
    put(8'hAA); put(8'hBB);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    load(1, "t1_done");
    check_eq("t1_nwr", wcnt1 - base, 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq("t1_addr", {16'd0, wa1[(base + k) % 64]}, 32'h0500 + k);
      check_eq("t1_data", {24'd0, wd1[(base + k) % 64]}, 32'((k + 1) * 17));
    end
    check_eq("t1_lp",   {16'd0, bus1.loadpoint}, 32'h0500);
    check_eq("t1_auto", {31'd0, bus1.tape_autorun}, 32'd1);
    check_eq("t1_cmpl", {31'd0, bus1.tape_complete}, 32'd1);
    check_eq("t1_err",  {31'd0, bus1.error}, 32'd0);
    check_eq("t1_busy", {31'd0, bus1.busy}, 32'd0);

    // RD_LAT=2, autorun off, 3-cycle spacing between writes
    tlen = 0;
    make_prog(8'h00, 16'h0502, 16'h0500, 4, 2, 3);
    bus2.tape_end = 25'(tlen - 1);
    base = wcnt2;
    load(2, "t2_done");
    check_eq("t2_nwr", wcnt2 - base, 32'd3);
    for (int k = 0; k < 3; k++) begin
      check_eq("t2_addr", {16'd0, wa2[(base + k) % 64]}, 32'h0500 + k);
      check_eq("t2_data", {24'd0, wd2[(base + k) % 64]}, 32'((k + 1) * 17));
    end
    check_eq("t2_gap1", wcyc2[(base + 1) % 64] - wcyc2[base % 64], 32'd3);
    check_eq("t2_gap2", wcyc2[(base + 2) % 64] - wcyc2[(base + 1) % 64], 32'd3);
    check_eq("t2_auto", {31'd0, bus2.tape_autorun}, 32'd0);
    check_eq("t2_cmpl", {31'd0, bus2.tape_complete}, 32'd1);

    // Short sync run before the real one is rejected
    tlen = 0;
    put(8'h16); put(8'h16); put(8'h24);
    make_prog(8'hC7, 16'h0502, 16'h0500, 3, 2, 3);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    load(1, "t3_done");
    check_eq("t3_nwr",  wcnt1 - base, 32'd3);
    check_eq("t3_cmpl", {31'd0, bus1.tape_complete}, 32'd1);
    check_eq("t3_addr", {16'd0, wa1[(base + 2) % 64]}, 32'h0502);

    // End below start
    tlen = 0;
    make_prog(8'hC7, 16'h04FF, 16'h0500, 4, 2, 3);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    load(1, "t4_done");
    check_eq("t4_err",  {31'd0, bus1.error}, 32'd1);
    check_eq("t4_cmpl", {31'd0, bus1.tape_complete}, 32'd0);
    check_eq("t4_nwr",  wcnt1 - base, 32'd0);

    // Cache one byte short of the payload
    tlen = 0;
    make_prog(8'hC7, 16'h0502, 16'h0500, 4, 2, 3);
    bus1.tape_end = 25'(tlen - 2);
    base = wcnt1;
    load(1, "t5_done");
    check_eq("t5_nwr",  wcnt1 - base, 32'd2);
    check_eq("t5_err",  {31'd0, bus1.error}, 32'd1);
    check_eq("t5_cmpl", {31'd0, bus1.tape_complete}, 32'd0);

    // Filename length limit: 16 accepted, 17 rejected
    tlen = 0;
    make_prog(8'h01, 16'h0700, 16'h0700, 4, 16, 1);
    bus1.tape_end = 25'(tlen - 1);
    load(1, "t6a_done");
    check_eq("t6a_cmpl", {31'd0, bus1.tape_complete}, 32'd1);
    check_eq("t6a_lp",   {16'd0, bus1.loadpoint}, 32'h0700);
    tlen = 0;
    make_prog(8'h01, 16'h0700, 16'h0700, 4, 17, 1);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    load(1, "t6b_done");
    check_eq("t6b_err", {31'd0, bus1.error}, 32'd1);
    check_eq("t6b_nwr", wcnt1 - base, 32'd0);

    // Abort after the first payload write, then reload
    tlen = 0;
    make_prog(8'hC7, 16'h0502, 16'h0500, 4, 2, 3);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    seen = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus1.tape_wr) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t7_wr_seen", {31'd0, seen}, 32'd1);
    bus1.abort = 1'b1;
    @(negedge clk);
    check_eq("t7_busy", {31'd0, bus1.busy}, 32'd0);
    check_eq("t7_rdwr", {30'd0, bus1.cache_rd, bus1.tape_wr}, 32'd0);
    check_eq("t7_flags", {30'd0, bus1.tape_complete, bus1.error}, 32'd0);
    bus1.abort = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t7_nwr", wcnt1 - base, 32'd1);
    base = wcnt1;
    load(1, "t7_reload");
    check_eq("t7_nwr2", wcnt1 - base, 32'd3);
    check_eq("t7_cmpl", {31'd0, bus1.tape_complete}, 32'd1);

`ifdef TAPLOAD_MULTI_EN
    // Two concatenated programs
    tlen = 0;
    make_prog(8'hC7, 16'h0502, 16'h0500, 4, 2, 3);
    make_prog(8'h00, 16'h0601, 16'h0600, 3, 1, 2);
    bus1.tape_end = 25'(tlen - 1);
    base = wcnt1;
    load(1, "t8_done");
    check_eq("t8_nwr",  wcnt1 - base, 32'd5);
    check_eq("t8_a3",   {16'd0, wa1[(base + 3) % 64]}, 32'h0600);
    check_eq("t8_d4",   {24'd0, wd1[(base + 4) % 64]}, 32'h22);
    check_eq("t8_lp",   {16'd0, bus1.loadpoint}, 32'h0600);
    check_eq("t8_auto", {31'd0, bus1.tape_autorun}, 32'd0);
    check_eq("t8_cmpl", {31'd0, bus1.tape_complete}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
